// File: rtl/tcp_bram_pkg.sv
// ---------------------------------------------------------------------------
// tcp_bram_pkg
//   Shared encodings for the TX data-buffer BRAM port-B arbiter.
//   - Arbiter FSM state encoding (S_IDLE / S_WR / S_RD)
//   - Client identifiers used for round-robin bookkeeping (CL_WR / CL_RD)
// ---------------------------------------------------------------------------
package tcp_bram_pkg;

  // FSM states. Plain constants keep the encoding visible in waveforms and
  // compatible with older tools that consume this package.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  // Client ids stored in last_served.
  localparam logic CL_WR = 1'b0;
  localparam logic CL_RD = 1'b1;

endpackage

// File: rtl/bram_rd_valid_pipe.sv
// ---------------------------------------------------------------------------
// bram_rd_valid_pipe
//   Tracks accepted read beats through port-B register stage plus the BRAM
//   read latency, so the return strobe lines up with doutb.
//   A beat entered in accept cycle T appears on out_valid in cycle
//   T+1+RD_LATENCY. The oob bit rides along so the top can zero rd_data for
//   out-of-range reads.
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; flushes every stage
//   in_valid   in   read beat accepted this cycle
//   in_oob     in   that beat's address was out of range
//   out_valid  out  read data for the oldest beat is on doutb this cycle
//   out_oob    out  that beat was out of range
// ---------------------------------------------------------------------------
module bram_rd_valid_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_oob,
  output logic out_valid,
  output logic out_oob
);

  localparam int DEPTH = 1 + RD_LATENCY;

  logic [DEPTH-1:0] vld_sr;
  logic [DEPTH-1:0] oob_sr;

  // Clearing on reset is what discards in-flight read returns.
  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
      oob_sr <= '0;
    end else begin
      vld_sr[0] <= in_valid;
      oob_sr[0] <= in_oob;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        oob_sr[i] <= oob_sr[i-1];
      end
    end
  end

  assign out_valid = vld_sr[DEPTH-1];
  assign out_oob   = oob_sr[DEPTH-1];

endmodule

// File: rtl/bram_portb_arbiter.sv
// ---------------------------------------------------------------------------
// bram_portb_arbiter
//   Shares TX data-buffer BRAM port B between the RX payload writer (write
//   client) and the TX read path (read client). Bursts are granted
//   round-robin and capped at MAX_BURST beats. Port-B pins are registered;
//   read data comes back straight from doutb, tagged by rd_valid.
// Ports
//   clk, reset         single clock; synchronous active-high reset
//   wr_req/addr/data/last, wr_gnt   write client beat handshake
//   rd_req/addr/last, rd_gnt        read client beat handshake
//   rd_data, rd_valid               read return (one pulse per read beat)
//   address_b, datain_b, enb, web   registered BRAM port-B controls
//   doutb                           BRAM port-B read data
//   addr_err                        sticky: an out-of-range beat was accepted
// ---------------------------------------------------------------------------
module bram_portb_arbiter
  import tcp_bram_pkg::*;
#(
  parameter int DATA_BITS  = 512,
  parameter int ADDR_BITS  = 10,
  parameter int MEM_DEPTH  = 1024,
  parameter int MAX_BURST  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_last,
  output logic                 wr_gnt,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_last,
  output logic                 rd_gnt,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic [ADDR_BITS-1:0] address_b,
  output logic [DATA_BITS-1:0] datain_b,
  output logic                 enb,
  output logic                 web,
  input  logic [DATA_BITS-1:0] doutb,
  output logic                 addr_err
);

  localparam int                   CNT_BITS = $clog2(MAX_BURST + 1);
  localparam logic [CNT_BITS-1:0]  CNT_LAST = CNT_BITS'(MAX_BURST - 1);
  localparam int unsigned          DEPTH_U  = MEM_DEPTH;

  logic [1:0]          state, state_nxt;
  logic                last_served, last_served_nxt;
  logic [CNT_BITS-1:0] beat_cnt, beat_cnt_nxt;

  logic                 owner_req, owner_last, other_req;
  logic                 accept, in_range;
  logic [ADDR_BITS-1:0] sel_addr;
  logic                 pipe_valid, pipe_oob;

  // Grants come straight off the state register; reset masks them in the
  // reset cycle itself.
  assign wr_gnt = (state == S_WR) & wr_req & ~reset;
  assign rd_gnt = (state == S_RD) & rd_req & ~reset;
  assign accept = wr_gnt | rd_gnt;

  assign owner_req  = (state == S_WR) ? wr_req  : rd_req;
  assign owner_last = (state == S_WR) ? wr_last : rd_last;
  assign other_req  = (state == S_WR) ? rd_req  : wr_req;

  assign sel_addr = rd_gnt ? rd_addr : wr_addr;
  assign in_range = (32'(sel_addr) < DEPTH_U);

  // -------------------------------------------------------------------------
  // Arbitration FSM
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    beat_cnt_nxt    = beat_cnt;
    case (state)
      S_IDLE: begin
        // Idle cycles accept nothing; they only pick the next owner.
        if (wr_req && rd_req)
          state_nxt = (last_served == CL_RD) ? S_WR : S_RD;
        else if (wr_req)
          state_nxt = S_WR;
        else if (rd_req)
          state_nxt = S_RD;
      end
      S_WR, S_RD: begin
        // A dropped owner request ends the burst without a beat; otherwise
        // the beat is accepted and may itself be the last one.
        if (!owner_req || owner_last || (beat_cnt == CNT_LAST)) begin
          last_served_nxt = (state == S_WR) ? CL_WR : CL_RD;
          beat_cnt_nxt    = '0;
          // Hand over directly when the other side waits: no idle bubble.
          if (other_req)
            state_nxt = (state == S_WR) ? S_RD : S_WR;
          else if (owner_req)
            state_nxt = state;
          else
            state_nxt = S_IDLE;
        end else begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      last_served <= CL_RD;   // write wins the first tie after reset
      beat_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      beat_cnt    <= beat_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Registered port-B drive. Out-of-range beats are accepted but never reach
  // the BRAM (enb stays low); address_b still records the offending address.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      enb       <= 1'b0;
      web       <= 1'b0;
      address_b <= '0;
      datain_b  <= '0;
      addr_err  <= 1'b0;
    end else begin
      enb <= accept & in_range;
      web <= wr_gnt & in_range;
      if (accept) begin
        address_b <= sel_addr;
        datain_b  <= wr_gnt ? wr_data : '0;
      end
      if (accept && !in_range)
        addr_err <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Read return alignment
  // -------------------------------------------------------------------------
  bram_rd_valid_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_valid_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_gnt),
    .in_oob    (rd_gnt & ~in_range),
    .out_valid (pipe_valid),
    .out_oob   (pipe_oob)
  );

  // The pipe only clears at the reset edge, so mask the strobe during reset
  // to drop the pulse that would otherwise leak out in that cycle.
  assign rd_valid = pipe_valid & ~reset;
  assign rd_data  = pipe_oob ? '0 : doutb;

endmodule
